instr_loader: RTL



---
 rtl/loader_pkg.sv | 27 ++
 rtl/byte_timeout_timer.sv | 39 +++
 rtl/instr_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the byte-serial instruction loader: framing constants,
// 17-bit instruction field positions, legal opcode limit and the loader states.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         INSTR_W     = 17;
    localparam int         OPCODE_MSB  = 16;
    localparam int         OPCODE_LSB  = 12;
    localparam logic [4:0] LAST_OPCODE = 5'd21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_W0,
        ST_W1,
        ST_W2,
        ST_CSUM
    } load_state_t;

    // A word is legal when the unused high bits of its first byte are zero
    // and its opcode does not exceed LSR.
    function automatic logic word_legal(input logic [6:0]         b0_hi,
                                        input logic [INSTR_W-1:0] word);
        return (b0_hi == 7'd0) && (word[OPCODE_MSB:OPCODE_LSB] <= LAST_OPCODE);
    endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: reloads to TIMEOUT on clr, counts down while enabled,
// and flags expiry on the TIMEOUT-th consecutive enabled cycle without a clear.
module byte_timeout_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Reload on clear (clear beats expiry), otherwise count down while enabled.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = CW'(TIMEOUT);
        end else if (en && (count_reg != '0)) begin
            count_next = count_reg - CW'(1);
        end
    end

    assign expire = en && !clr && (count_reg == CW'(1));

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= CW'(TIMEOUT);
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Framed byte-stream program loader: assembles 17-bit instruction words from
// three bytes each, replaces illegal words with NOP, writes them to instruction
// memory and holds the CPU off while a frame is in progress.
// Optional trailing XOR checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err_len,
    output logic               err_opcode,
    output logic               err_csum,
    output logic               err_timeout
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    load_state_t        state_reg, state_next;
    logic [7:0]         cnt_reg, cnt_next;
    logic [ADDR_W-1:0]  ptr_reg, ptr_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [INSTR_W-1:0] wdata_reg, wdata_next;
    logic               we_reg, we_next;
    logic               done_reg, done_next;
    logic               hold_reg, hold_next;
    logic [7:0]         b0_reg, b0_next;
    logic [7:0]         b1_reg, b1_next;
    logic               err_len_reg, err_len_next;
    logic               err_opcode_reg, err_opcode_next;
    logic               err_timeout_reg, err_timeout_next;
    logic               in_ready_reg;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]         csum_reg, csum_next;
    logic               err_csum_reg, err_csum_next;
`endif

    logic               accept;
    logic               expire;
    logic [INSTR_W-1:0] word_in;
    logic               word_ok;

    assign accept  = in_valid && in_ready_reg;
    assign word_in = {b0_reg[0], b1_reg, in_data};
    assign word_ok = word_legal(b0_reg[7:1], word_in);

    byte_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept || (state_reg == ST_IDLE)),
        .en     (state_reg != ST_IDLE),
        .expire (expire)
    );

    // Frame parser: next state, word assembly, write strobe and flags.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        ptr_next         = ptr_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        we_next          = 1'b0;
        done_next        = 1'b0;
        hold_next        = hold_reg;
        b0_next          = b0_reg;
        b1_next          = b1_reg;
        err_len_next     = err_len_reg;
        err_opcode_next  = err_opcode_reg;
        err_timeout_next = err_timeout_reg;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_next        = csum_reg;
        err_csum_next    = err_csum_reg;
`endif
        if (expire) begin
            // Expiry is already suppressed in a cycle that accepts a byte.
            err_timeout_next = 1'b1;
            hold_next        = 1'b0;
            state_next       = ST_IDLE;
        end else if (accept) begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_next       = ST_LEN;
                        hold_next        = 1'b1;
                        ptr_next         = BASE;
                        addr_next        = BASE;
                        err_len_next     = 1'b0;
                        err_opcode_next  = 1'b0;
                        err_timeout_next = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum_next        = 8'h00;
                        err_csum_next    = 1'b0;
`endif
                    end
                end
                ST_LEN: begin
                    if (in_data == 8'd0) begin
                        err_len_next = 1'b1;
                        hold_next    = 1'b0;
                        state_next   = ST_IDLE;
                    end else begin
                        cnt_next   = in_data;
                        state_next = ST_W0;
                    end
                end
                ST_W0: begin
                    b0_next    = in_data;
                    state_next = ST_W1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_next  = csum_reg ^ in_data;
`endif
                end
                ST_W1: begin
                    b1_next    = in_data;
                    state_next = ST_W2;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_next  = csum_reg ^ in_data;
`endif
                end
                ST_W2: begin
                    we_next    = 1'b1;
                    addr_next  = ptr_reg;
                    ptr_next   = ptr_reg + ADDR_W'(1);
                    wdata_next = word_ok ? word_in : '0;
                    if (!word_ok) begin
                        err_opcode_next = 1'b1;
                    end
                    cnt_next = cnt_reg - 8'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_next = csum_reg ^ in_data;
`endif
                    if (cnt_reg == 8'd1) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        done_next  = 1'b1;
                        hold_next  = 1'b0;
                        state_next = ST_IDLE;
`endif
                    end else begin
                        state_next = ST_W0;
                    end
                end
                ST_CSUM: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    if (in_data != csum_reg) begin
                        err_csum_next = 1'b1;
                    end
                    done_next = 1'b1;
                    hold_next = 1'b0;
`endif
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= 8'd0;
            ptr_reg         <= BASE;
            addr_reg        <= BASE;
            wdata_reg       <= '0;
            we_reg          <= 1'b0;
            done_reg        <= 1'b0;
            hold_reg        <= 1'b0;
            b0_reg          <= 8'd0;
            b1_reg          <= 8'd0;
            err_len_reg     <= 1'b0;
            err_opcode_reg  <= 1'b0;
            err_timeout_reg <= 1'b0;
            in_ready_reg    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_reg        <= 8'h00;
            err_csum_reg    <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            ptr_reg         <= ptr_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            we_reg          <= we_next;
            done_reg        <= done_next;
            hold_reg        <= hold_next;
            b0_reg          <= b0_next;
            b1_reg          <= b1_next;
            err_len_reg     <= err_len_next;
            err_opcode_reg  <= err_opcode_next;
            err_timeout_reg <= err_timeout_next;
            in_ready_reg    <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_reg        <= csum_next;
            err_csum_reg    <= err_csum_next;
`endif
        end
    end

    assign in_ready    = in_ready_reg;
    assign imem_we     = we_reg;
    assign imem_addr   = addr_reg;
    assign imem_wdata  = wdata_reg;
    assign cpu_hold    = hold_reg;
    assign done        = done_reg;
    assign err_len     = err_len_reg;
    assign err_opcode  = err_opcode_reg;
    assign err_timeout = err_timeout_reg;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign err_csum    = err_csum_reg;
`else
    assign err_csum    = 1'b0;
`endif

endmodule
